game_outcome: RTL and testbench

Parametrised game-outcome controller for the bomb. It replaces the single-bit explode latch with a full round state machine. It aggregates per-module strike requests and the timer expiry, and counts strikes against a configurable limit. It also detects the win condition (all modules solved) and reports a registered outcome, strike count and loss cause to the display and sound logic.

---
 rtl/game_outcome.sv | 115 +++++++++++
 tb/tb_game_outcome.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/game_outcome.sv
// rtl/game_outcome.sv - round state machine for the bomb: strike counting, timer loss, win detect
// Registered outcome, strike count and loss cause for the display and sound logic.
module game_outcome #(
  parameter int NUM_MODULES = 5,
  parameter int MAX_STRIKES = 3,
  parameter int STRIKE_W    = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic                   explode_timer_i,
  input  logic [NUM_MODULES-1:0] strike_i,
  input  logic [NUM_MODULES-1:0] solved_i,
  output logic [1:0]             state_o,
  output logic                   game_lost_o,
  output logic                   game_won_o,
  output logic [STRIKE_W-1:0]    strikes_o,
  output logic                   strike_event_o,
  output logic [1:0]             lose_cause_o
);

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_ARMED = 2'b01;
  localparam logic [1:0] S_LOST  = 2'b10;
  localparam logic [1:0] S_WON   = 2'b11;

  localparam int CNT_W = $clog2(NUM_MODULES + 1);
  // Sum is one bit wider than either operand so strikes + n can never wrap before saturation.
  localparam int SUM_W = ((STRIKE_W > CNT_W) ? STRIKE_W : CNT_W) + 1;
  localparam logic [SUM_W-1:0] MAX_W = SUM_W'(MAX_STRIKES);

  logic [1:0]             state_q, state_d;
  logic [STRIKE_W-1:0]    strikes_q, strikes_d;
  logic [1:0]             cause_q, cause_d;
  logic                   event_q, event_d;
  logic                   lost_q, won_q;
  logic [NUM_MODULES-1:0] strike_q;

  logic [NUM_MODULES-1:0] strike_rise;
  logic [NUM_MODULES-1:0] accepted;
  logic [CNT_W-1:0]       n_acc;
  logic [SUM_W-1:0]       sum_w;
  logic [STRIKE_W-1:0]    next_strikes;
  logic                   t_lose, s_lose;

  assign strike_rise = strike_i & ~strike_q;
  assign accepted    = strike_rise & ~solved_i;

  always_comb begin
    n_acc = '0;
    for (int i = 0; i < NUM_MODULES; i++) begin
      n_acc = n_acc + CNT_W'(accepted[i]);
    end
  end

  assign sum_w        = SUM_W'(strikes_q) + SUM_W'(n_acc);
  assign s_lose       = (sum_w >= MAX_W);
  assign t_lose       = explode_timer_i;
  assign next_strikes = s_lose ? MAX_W[STRIKE_W-1:0] : sum_w[STRIKE_W-1:0];

  always_comb begin
    state_d   = state_q;
    strikes_d = strikes_q;
    cause_d   = cause_q;
    event_d   = 1'b0;
    case (state_q)
      S_ARMED: begin
        strikes_d = next_strikes;
        event_d   = (n_acc != '0);
        // Loss is checked first so it wins over a simultaneous full solve.
        if (t_lose || s_lose) begin
          state_d = S_LOST;
          cause_d = {s_lose, t_lose};
        end else if (&solved_i) begin
          state_d = S_WON;
        end
      end
      S_IDLE, S_LOST, S_WON: begin
        if (start_i) begin
          state_d   = S_ARMED;
          strikes_d = '0;
          cause_d   = 2'b00;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      strikes_q <= '0;
      cause_q   <= 2'b00;
      event_q   <= 1'b0;
      lost_q    <= 1'b0;
      won_q     <= 1'b0;
      strike_q  <= '0;
    end else begin
      state_q   <= state_d;
      strikes_q <= strikes_d;
      cause_q   <= cause_d;
      event_q   <= event_d;
      lost_q    <= (state_d == S_LOST);
      won_q     <= (state_d == S_WON);
      strike_q  <= strike_i;
    end
  end

  assign state_o        = state_q;
  assign game_lost_o    = lost_q;
  assign game_won_o     = won_q;
  assign strikes_o      = strikes_q;
  assign strike_event_o = event_q;
  assign lose_cause_o   = cause_q;

endmodule

// File: tb/tb_game_outcome.sv
// tb/tb_game_outcome.sv - randomized and directed bench for game_outcome with a behavioural model
module tb_game_outcome;
  localparam int NM  = 5;
  localparam int MAX = 3;

  logic        clk, rst_n, start, timer;
  logic [4:0]  strike, solved;
  logic [1:0]  state, cause;
  logic        lost, won, ev;
  logic [1:0]  strikes;

  int checks = 0;
  int errors = 0;

  logic [1:0] m_state;
  int         m_strikes;
  logic [1:0] m_cause;
  logic       m_event;
  logic [4:0] m_prev;

  game_outcome #(.NUM_MODULES(NM), .MAX_STRIKES(MAX), .STRIKE_W(2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .explode_timer_i(timer),
    .strike_i(strike), .solved_i(solved), .state_o(state), .game_lost_o(lost),
    .game_won_o(won), .strikes_o(strikes), .strike_event_o(ev), .lose_cause_o(cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%0d expected=%0d", nm, $time, act, exp);
    end
  endtask

  // Reference: rounds described by rules, strikes as a plain saturating integer.
  always @(posedge clk or negedge rst_n) begin : model
    int n, tot;
    logic [4:0] acc;
    if (!rst_n) begin
      m_state <= 2'd0; m_strikes <= 0; m_cause <= 2'd0; m_event <= 1'b0; m_prev <= 5'd0;
    end else begin
      acc = strike & ~m_prev & ~solved;
      n   = $countones(acc);
      m_prev  <= strike;
      m_event <= 1'b0;
      if (m_state == 2'd1) begin
        tot = m_strikes + n;
        if (tot > MAX) tot = MAX;
        m_strikes <= tot;
        m_event   <= (n != 0);
        if (timer || tot >= MAX) begin
          m_state <= 2'd2;
          m_cause <= {(tot >= MAX), timer};
        end else if (solved == 5'h1f) begin
          m_state <= 2'd3;
        end
      end else if (start) begin
        m_state <= 2'd1; m_strikes <= 0; m_cause <= 2'd0;
      end
    end
  end

  always @(negedge clk) begin
    chk("state", state, m_state);
    chk("game_lost", lost, m_state == 2'd2);
    chk("game_won", won, m_state == 2'd3);
    chk("strikes", strikes, m_strikes);
    chk("strike_event", ev, m_event);
    chk("lose_cause", cause, m_cause);
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; start = 0; timer = 0; strike = 0; solved = 0;
    tick(); tick();
    rst_n = 1'b1;
    chk("lit_reset_state", state, 2'd0);
    chk("lit_reset_strikes", strikes, 2'd0);

    // Held strike counts once; re-rise counts again.
    start = 1; tick(); start = 0;
    chk("lit_armed", state, 2'd1);
    strike = 5'b00001; tick();
    chk("lit_s1", strikes, 2'd1); chk("lit_ev1", ev, 1'b1);
    tick(); chk("lit_hold_ev", ev, 1'b0);
    tick(); chk("lit_hold_s", strikes, 2'd1);
    strike = 0; tick();
    strike = 5'b00001; tick();
    chk("lit_s2", strikes, 2'd2); chk("lit_ev2", ev, 1'b1); chk("lit_still_armed", state, 2'd1);
    // Timer and strike together at strikes=2.
    strike = 5'b00011; timer = 1; tick();
    strike = 0; timer = 0;
    chk("lit_both_state", state, 2'd2); chk("lit_both_cause", cause, 2'd3); chk("lit_both_s", strikes, 2'd3);
    start = 1; tick(); start = 0;
    chk("lit_restart_state", state, 2'd1); chk("lit_restart_s", strikes, 2'd0); chk("lit_restart_c", cause, 2'd0);
    // Multi-module strike saturates into loss.
    strike = 5'b00111; tick(); strike = 0;
    chk("lit_multi_s", strikes, 2'd3); chk("lit_multi_lost", lost, 1'b1);
    chk("lit_multi_c", cause, 2'd2); chk("lit_multi_ev", ev, 1'b1);
    start = 1; tick(); start = 0;
    // Loss beats win.
    solved = 5'h1f; timer = 1; tick(); solved = 0; timer = 0;
    chk("lit_prio_state", state, 2'd2); chk("lit_prio_c", cause, 2'd1); chk("lit_prio_won", won, 1'b0);
    start = 1; tick(); start = 0;
    // Solved modules cannot strike; full solve wins.
    solved = 5'b00001; tick(); solved = 5'b00011; tick(); solved = 5'b00111; tick();
    strike = 5'b00100; tick(); strike = 0;
    chk("lit_solved_s", strikes, 2'd0); chk("lit_solved_ev", ev, 1'b0);
    solved = 5'b01111; tick(); solved = 5'h1f; tick();
    chk("lit_won_state", state, 2'd3); chk("lit_won", won, 1'b1);
    solved = 0;
    // Asynchronous reset mid-round.
    start = 1; tick(); start = 0;
    strike = 5'b00001; tick(); strike = 0;
    chk("lit_pre_rst_s", strikes, 2'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("lit_async_state", state, 2'd0); chk("lit_async_s", strikes, 2'd0);
    chk("lit_async_ev", ev, 1'b0); chk("lit_async_lost", lost, 1'b0);
    tick(); rst_n = 1'b1;

    for (int c = 0; c < 4000; c++) begin
      start = 0;
      if (m_state != 2'd1) begin
        if ($urandom_range(0, 5) == 0) begin start = 1; solved = 0; end
      end else begin
        if ($urandom_range(0, 29) == 0) start = 1;
        if ($urandom_range(0, 5) == 0) solved[$urandom_range(0, 4)] = 1'b1;
      end
      strike = 5'($urandom & $urandom & $urandom);
      timer  = ($urandom_range(0, 39) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
